// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings,
// control-bundle type and constants. Reused by the hazard/forwarding logic.
package pipeline_stall_controller_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                 if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                   if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                   if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                   if_id_flush: 1'b1, id_ex_flush: 1'b1};

  // Extra flush cycles still owed after the branch cycle itself (valid for 1..3).
  function automatic logic [1:0] fcnt_load(input int flush_cycles);
    if (flush_cycles > 1) begin
      return 2'(flush_cycles - 1);
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-register controls between the pipeline and the
// stall controller. Counter signals exist only with PIPE_CTRL_PERF_EN.
interface pipeline_stall_controller_if
  import pipeline_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) ();

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_memread;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;
`endif

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush
`ifdef PIPE_CTRL_PERF_EN
    , input stall_count, flush_count
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush
`ifdef PIPE_CTRL_PERF_EN
    , output stall_count, flush_count
`endif
  );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Combinational load-use hazard compare; register x0 never creates a hazard.
module load_use_detector
  import pipeline_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  output logic                  o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_ex_rd != {REG_ADDR_W{1'b0}});
  assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_load_use   = i_ex_memread & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stage-register enable/flush sequencer: memory wait > branch flush > load-use stall.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W      = 32
`endif
) (
  input logic                        clock,
  input logic                        reset,
  pipeline_stall_controller_if.slave bus
);

  localparam logic [1:0] FCNT_LOAD = fcnt_load(FLUSH_CYCLES);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_fcnt;
  logic [1:0] w_fcnt_nxt;
  logic       w_load_use;
  logic       w_mem_wait;
  logic       w_branch_more;
  ctrl_t      w_run_ctrl;
  ctrl_t      w_ctrl;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .i_ex_memread (bus.ex_memread),
    .i_ex_rd      (bus.ex_rd),
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .o_load_use   (w_load_use)
  );

  assign w_mem_wait    = bus.mem_req & ~bus.mem_ready;
  assign w_branch_more = bus.ex_branch_taken & (FCNT_LOAD != 2'd0);

  // RUN-mode decode, also used in the MEMWAIT release cycle; branch squashes ID so it beats load-use
  always_comb begin
    w_run_ctrl = CTRL_RUN;
    if (bus.ex_branch_taken) begin
      w_run_ctrl = CTRL_FLUSH;
    end else if (w_load_use) begin
      w_run_ctrl = CTRL_STALL;
    end else begin
      w_run_ctrl = CTRL_RUN;
    end
  end

  // State register and remaining-flush counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (reset) begin
      w_ctrl      = CTRL_RESET;
      w_state_nxt = ST_RUN;
      w_fcnt_nxt  = 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_MEMWAIT;
          end else if (w_branch_more) begin
            w_ctrl      = w_run_ctrl;
            w_fcnt_nxt  = FCNT_LOAD;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_ctrl      = w_run_ctrl;
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // A memory wait suspends the flush with the remaining count preserved
          if (w_mem_wait) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_MEMWAIT;
          end else begin
            w_ctrl      = CTRL_FLUSH;
            w_fcnt_nxt  = (r_fcnt == 2'd0) ? 2'd0 : (r_fcnt - 2'd1);
            w_state_nxt = (r_fcnt <= 2'd1) ? ST_RUN : ST_FLUSH;
          end
        end
        ST_MEMWAIT: begin
          if (!bus.mem_ready) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_MEMWAIT;
          end else if (w_branch_more) begin
            w_ctrl      = w_run_ctrl;
            w_fcnt_nxt  = FCNT_LOAD;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_ctrl      = w_run_ctrl;
            w_state_nxt = (r_fcnt != 2'd0) ? ST_FLUSH : ST_RUN;
          end
        end
        default: begin
          w_ctrl      = CTRL_RESET;
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = 2'd0;
        end
      endcase
    end
  end

  assign bus.pc_write    = w_ctrl.pc_write;
  assign bus.if_id_write = w_ctrl.if_id_write;
  assign bus.id_ex_write = w_ctrl.id_ex_write;
  assign bus.if_id_flush = w_ctrl.if_id_flush;
  assign bus.id_ex_flush = w_ctrl.id_ex_flush;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  // Stall and flush cycle counters, free-running with natural wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= {CNT_W{1'b0}};
      r_flush_count <= {CNT_W{1'b0}};
    end else begin
      if (!w_ctrl.pc_write) begin
        r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_ctrl.if_id_flush) begin
        r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: three instances (FLUSH_CYCLES=1,2,3) share
// stimulus; a behavioural model checks every cycle, directed cases pin literals.
module tb_pipeline_stall_controller;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush}
  logic [4:0] act_ctl [3];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] act_stall [3];
  logic [31:0] act_flush [3];
`endif

  localparam logic [4:0] E_RUN    = 5'b11100;
  localparam logic [4:0] E_FREEZE = 5'b00000;
  localparam logic [4:0] E_FLUSH  = 5'b11111;
  localparam logic [4:0] E_STALL  = 5'b00101;
  localparam logic [4:0] E_RESET  = 5'b00011;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_stall_controller_if #(
      .REG_ADDR_W (5)
`ifdef PIPE_CTRL_PERF_EN
      , .CNT_W (32)
`endif
    ) bus ();

    assign bus.id_rs1          = id_rs1;
    assign bus.id_rs2          = id_rs2;
    assign bus.ex_rd           = ex_rd;
    assign bus.ex_memread      = ex_memread;
    assign bus.ex_branch_taken = ex_branch_taken;
    assign bus.mem_req         = mem_req;
    assign bus.mem_ready       = mem_ready;

    pipeline_stall_controller #(
      .REG_ADDR_W   (5),
      .FLUSH_CYCLES (g + 1)
`ifdef PIPE_CTRL_PERF_EN
      , .CNT_W (32)
`endif
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign act_ctl[g] = {bus.pc_write, bus.if_id_write, bus.id_ex_write,
                         bus.if_id_flush, bus.id_ex_flush};
`ifdef PIPE_CTRL_PERF_EN
    assign act_stall[g] = bus.stall_count;
    assign act_flush[g] = bus.flush_count;
`endif
  end

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (pc,ifw,idw,iff,idf)", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owed: flush cycles still to come; waiting: parked behind a memory wait
  int         m_owed    [3];
  bit         m_waiting [3];
  logic [4:0] m_exp;
  bit         m_lu;
  bit         m_mw;
`ifdef PIPE_CTRL_PERF_EN
  int unsigned m_stall [3];
  int unsigned m_flush [3];
  bit          m_cnt_valid = 1'b0;
`endif

  function automatic logic [4:0] run_rule(input bit branch, input bit lu);
    if (branch) return E_FLUSH;
    if (lu) return E_STALL;
    return E_RUN;
  endfunction

  always @(negedge clock) begin
    m_lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    m_mw = mem_req && !mem_ready;
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        m_exp        = E_RESET;
        m_owed[g]    = 0;
        m_waiting[g] = 1'b0;
      end else if (m_waiting[g]) begin
        if (!mem_ready) begin
          m_exp = E_FREEZE;
        end else begin
          m_exp        = run_rule(ex_branch_taken, m_lu);
          m_waiting[g] = 1'b0;
          if (ex_branch_taken) m_owed[g] = g;
        end
      end else if (m_mw) begin
        m_exp        = E_FREEZE;
        m_waiting[g] = 1'b1;
      end else if (m_owed[g] > 0) begin
        m_exp     = E_FLUSH;
        m_owed[g] = m_owed[g] - 1;
      end else begin
        m_exp = run_rule(ex_branch_taken, m_lu);
        if (ex_branch_taken) m_owed[g] = g;
      end
      chk5($sformatf("model_ctl[fc=%0d]", g + 1), act_ctl[g], m_exp);
`ifdef PIPE_CTRL_PERF_EN
      if (m_cnt_valid) begin
        chk32($sformatf("model_stall_count[fc=%0d]", g + 1), act_stall[g], m_stall[g]);
        chk32($sformatf("model_flush_count[fc=%0d]", g + 1), act_flush[g], m_flush[g]);
      end
      if (reset) begin
        m_stall[g] = 0;
        m_flush[g] = 0;
      end else begin
        if (!m_exp[4]) m_stall[g] = m_stall[g] + 1;
        if (m_exp[1]) m_flush[g] = m_flush[g] + 1;
      end
`endif
    end
`ifdef PIPE_CTRL_PERF_EN
    if (reset) m_cnt_valid = 1'b1;
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs1          = 5'd1;
    id_rs2          = 5'd2;
    ex_rd           = 5'd3;
    ex_memread      = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clock);
    chk5("reset_ctl", act_ctl[0], E_RESET);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk5("run_after_reset", act_ctl[2], E_RUN);
`ifdef PIPE_CTRL_PERF_EN
    chk32("stall_count_after_reset", act_stall[0], 32'd0);
`endif

    // load-use on rs2
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    @(negedge clock);
    chk5("load_use_stall", act_ctl[0], E_STALL);
    next_cycle();
    idle();
    @(negedge clock);
    chk5("load_use_release", act_ctl[0], E_RUN);

    // x0 never stalls
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge clock);
    chk5("x0_no_stall", act_ctl[0], E_RUN);

    // single-cycle branch: flush length follows FLUSH_CYCLES
    next_cycle();
    idle();
    ex_branch_taken = 1'b1;
    @(negedge clock);
    chk5("branch_c1_fc2", act_ctl[1], E_FLUSH);
    next_cycle();
    idle();
    @(negedge clock);
    chk5("branch_c2_fc1", act_ctl[0], E_RUN);
    chk5("branch_c2_fc2", act_ctl[1], E_FLUSH);
    next_cycle();
    @(negedge clock);
    chk5("branch_c3_fc2", act_ctl[1], E_RUN);
    chk5("branch_c3_fc3", act_ctl[2], E_FLUSH);
    next_cycle();
    @(negedge clock);
    chk5("branch_c4_fc3", act_ctl[2], E_RUN);

    // three-cycle memory wait then release
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      @(negedge clock);
      chk5($sformatf("memwait_frozen_%0d", i), act_ctl[0], E_FREEZE);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clock);
    chk5("memwait_release", act_ctl[0], E_RUN);
    next_cycle();
    idle();
    @(negedge clock);
    chk5("memwait_after", act_ctl[1], E_RUN);

    // branch and load-use together: flush only
    next_cycle();
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    @(negedge clock);
    chk5("branch_beats_load_use", act_ctl[0], E_FLUSH);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
    end
    @(negedge clock);
    chk5("drained_fc3", act_ctl[2], E_RUN);

    // reset during the second FLUSH cycle of FLUSH_CYCLES=3
    next_cycle();
    ex_branch_taken = 1'b1;
    @(negedge clock);
    chk5("pre_reset_flush", act_ctl[2], E_FLUSH);
    next_cycle();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk5("reset_mid_flush", act_ctl[2], E_RESET);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk5("no_residual_flush", act_ctl[2], E_RUN);
`ifdef PIPE_CTRL_PERF_EN
    chk32("stall_count_cleared", act_stall[2], 32'd0);
    chk32("flush_count_cleared", act_flush[2], 32'd0);
`endif

    // randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset           = ($urandom_range(0, 99) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_memread      = ($urandom_range(0, 9) < 3);
      ex_branch_taken = ($urandom_range(0, 9) < 2);
      mem_req         = ($urandom_range(0, 9) < 3);
      mem_ready       = ($urandom_range(0, 1) == 1);
    end
    next_cycle();
    idle();
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
